// File: rtl/fila_scheduler_if.sv
// Handshake bundle between the fila scheduler and its queue/deserializer/user environment.
// master = scheduler side, slave = environment side.
interface fila_scheduler_if #(
  parameter int unsigned LEN_W = 3
);
  logic [LEN_W-1:0] len_in;
  logic             data_ready_in;
  logic             dequeue_req_in;
  logic             auto_en_in;
  logic             enqueue_out;
  logic             dequeue_out;
  logic             ack_out;
  logic             busy_out;
  logic             overflow_out;
  logic [2:0]       burst_cnt_out;

  modport master (
    input  len_in, data_ready_in, dequeue_req_in, auto_en_in,
    output enqueue_out, dequeue_out, ack_out, busy_out, overflow_out, burst_cnt_out
  );

  modport slave (
    output len_in, data_ready_in, dequeue_req_in, auto_en_in,
    input  enqueue_out, dequeue_out, ack_out, busy_out, overflow_out, burst_cnt_out
  );
endinterface

// File: rtl/fila_scheduler.sv
// Byte-queue sequencer in the clk_10KHz domain: turns data_ready edges into enqueue/ack pulses
// and issues manual or watermark-triggered burst dequeues, never overlapping with an enqueue.
module fila_scheduler #(
  parameter int unsigned LEN_W      = 3,
  parameter int unsigned FULL_LEVEL = 7,
  parameter int unsigned HIGH_WM    = 6,
  parameter int unsigned BURST_MAX  = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input logic              clk_10KHz,
  input logic              reset,
  fila_scheduler_if.master bus
);
  localparam int unsigned GapW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [LEN_W-1:0] FullLvl  = LEN_W'(FULL_LEVEL);
  localparam logic [LEN_W-1:0] HighWm   = LEN_W'(HIGH_WM);
  localparam logic [2:0]       BurstMax = 3'(BURST_MAX);
  localparam logic [GapW-1:0]  GapLoad  = GapW'(GAP_CYCLES);
  localparam logic [GapW-1:0]  GapOne   = GapW'(1);

  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  state_e          state_q;
  logic            data_ready_q, req_q;
  logic            enqueue_q, dequeue_q, ack_q, busy_q, overflow_q, auto_q;
  logic [2:0]      burst_cnt_q;
  logic [GapW-1:0] gap_cnt_q;

  logic       ready_rise, req_rise, has_room, not_empty;
  logic       enq_d, auto_start, manual_start, may_continue;
  logic [2:0] limit;

  assign ready_rise   = bus.data_ready_in & ~data_ready_q;
  assign req_rise     = bus.dequeue_req_in & ~req_q;
  assign has_room     = bus.len_in < FullLvl;
  assign not_empty    = bus.len_in != '0;
  assign enq_d        = ready_rise & has_room;
  assign auto_start   = bus.auto_en_in & (bus.len_in >= HighWm);
  assign manual_start = req_rise & not_empty;
  assign limit        = auto_q ? BurstMax : 3'd1;
  assign may_continue = (burst_cnt_q < limit) & not_empty & (~auto_q | bus.auto_en_in);

  always_ff @(posedge clk_10KHz) begin
    if (reset) begin
      state_q      <= StIdle;
      data_ready_q <= 1'b0;
      req_q        <= 1'b0;
      enqueue_q    <= 1'b0;
      dequeue_q    <= 1'b0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      auto_q       <= 1'b0;
      burst_cnt_q  <= 3'd0;
      gap_cnt_q    <= '0;
    end else begin
      data_ready_q <= bus.data_ready_in;
      req_q        <= bus.dequeue_req_in;
      enqueue_q    <= enq_d;
      ack_q        <= enqueue_q;
      dequeue_q    <= 1'b0;
      if (ready_rise && !has_room) begin
        overflow_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (auto_start || manual_start) begin
            state_q <= StIssue;
            busy_q  <= 1'b1;
            auto_q  <= auto_start;
          end
        end
        StIssue: begin
          // Strobes are registered, so an enqueue launching now would share the next cycle.
          if (!enq_d) begin
            dequeue_q <= 1'b1;
            gap_cnt_q <= GapLoad;
            state_q   <= StGap;
            if (burst_cnt_q < BurstMax) begin
              burst_cnt_q <= burst_cnt_q + 3'd1;
            end
          end
        end
        StGap: begin
          gap_cnt_q <= gap_cnt_q - GapOne;
          if (gap_cnt_q == GapOne) begin
            if (may_continue) begin
              state_q <= StIssue;
            end else begin
              state_q     <= StIdle;
              busy_q      <= 1'b0;
              burst_cnt_q <= 3'd0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.enqueue_out   = enqueue_q;
  assign bus.dequeue_out   = dequeue_q;
  assign bus.ack_out       = ack_q;
  assign bus.busy_out      = busy_q;
  assign bus.overflow_out  = overflow_q;
  assign bus.burst_cnt_out = burst_cnt_q;
endmodule

// File: tb/tb_fila_scheduler.sv
// Self-checking bench for fila_scheduler: directed scenarios plus random traffic against a
// timestamp-based reference model and a simple fila occupancy model.
module tb_fila_scheduler;
  localparam int FULL  = 7;
  localparam int HIGH  = 6;
  localparam int BURST = 4;
  localparam int GAP   = 2;

  logic clk = 1'b0;
  logic reset;
  fila_scheduler_if bus ();

  fila_scheduler dut (
    .clk_10KHz (clk),
    .reset     (reset),
    .bus       (bus)
  );

  always #50 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int len_m    = 0;
  int cyc      = 0;
  bit dr_prev  = 0;
  bit req_prev = 0;
  bit act      = 0;
  bit auto_b   = 0;
  int lim      = 1;
  int issue_t  = -1;
  int gap_end  = -1;
  bit e_enq = 0, e_deq = 0, e_ack = 0, e_busy = 0, e_ovf = 0;
  int e_cnt = 0;

  function automatic logic [7:0] obs();
    return {bus.enqueue_out, bus.dequeue_out, bus.ack_out, bus.busy_out, bus.overflow_out,
            bus.burst_cnt_out};
  endfunction

  function automatic logic [7:0] expv();
    return {e_enq, e_deq, e_ack, e_busy, e_ovf, 3'(e_cnt)};
  endfunction

  // Predicts the outputs after the coming edge from the inputs presented now.
  task automatic model_step();
    bit rr, qr, enq_n, deq_n;
    int nl;
    cyc++;
    nl = len_m;
    if (e_enq && nl < FULL) nl++;
    if (e_deq && nl > 0) nl--;
    if (reset) begin
      dr_prev = 0; req_prev = 0; act = 0; e_cnt = 0; issue_t = -1; gap_end = -1;
      e_enq = 0; e_deq = 0; e_ack = 0; e_busy = 0; e_ovf = 0;
    end else begin
      rr = bus.data_ready_in && !dr_prev;
      qr = bus.dequeue_req_in && !req_prev;
      dr_prev  = bus.data_ready_in;
      req_prev = bus.dequeue_req_in;
      enq_n = rr && (len_m < FULL);
      if (rr && len_m >= FULL) e_ovf = 1;
      deq_n = 0;
      if (!act) begin
        if (bus.auto_en_in && len_m >= HIGH) begin
          act = 1; auto_b = 1; lim = BURST; issue_t = cyc + 1;
        end else if (qr && len_m != 0) begin
          act = 1; auto_b = 0; lim = 1; issue_t = cyc + 1;
        end
      end else if (cyc == issue_t) begin
        if (enq_n) issue_t = cyc + 1;
        else begin
          deq_n = 1;
          if (e_cnt < BURST) e_cnt++;
          gap_end = cyc + GAP;
        end
      end else if (cyc == gap_end) begin
        if (e_cnt < lim && len_m != 0 && (!auto_b || bus.auto_en_in)) issue_t = cyc + 1;
        else begin
          act = 0; e_cnt = 0;
        end
      end
      e_ack = e_enq; e_enq = enq_n; e_deq = deq_n; e_busy = act;
    end
    len_m = nl;
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    bus.len_in = 3'(len_m);
  endtask

  task automatic set_len(input int v);
    len_m = v;
    bus.len_in = 3'(v);
  endtask

  task automatic test_reset();
    reset = 1;
    bus.data_ready_in = 0; bus.dequeue_req_in = 0; bus.auto_en_in = 0;
    set_len(0);
    repeat (2) tick();
    n_cmp++;
    if (obs() !== 8'h00) begin
      n_fail++; $display("FAIL reset_outputs got=%b want=%b", obs(), 8'h00);
    end
    reset = 0;
    tick();
  endtask

  task automatic test_enqueue();
    int enq_n = 0, ack_n = 0, first_enq = -1, first_ack = -1;
    set_len(0);
    bus.data_ready_in = 1;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) bus.data_ready_in = 0;
      tick();
      n_cmp++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL enqueue_trace i=%0d got=%b want=%b", i, obs(), expv());
      end
      if (bus.enqueue_out) begin enq_n++; if (first_enq < 0) first_enq = i; end
      if (bus.ack_out) begin ack_n++; if (first_ack < 0) first_ack = i; end
    end
    n_cmp++;
    if (enq_n !== 1 || first_enq !== 0) begin
      n_fail++; $display("FAIL enqueue_once count=%0d at=%0d want 1 at 0", enq_n, first_enq);
    end
    n_cmp++;
    if (ack_n !== 1 || first_ack !== 1) begin
      n_fail++; $display("FAIL ack_once count=%0d at=%0d want 1 at 1", ack_n, first_ack);
    end
  endtask

  task automatic test_overflow();
    int enq_n = 0;
    set_len(7);
    bus.data_ready_in = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) bus.data_ready_in = 0;
      tick();
      n_cmp++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL overflow_trace i=%0d got=%b want=%b", i, obs(), expv());
      end
      if (bus.enqueue_out || bus.ack_out) enq_n++;
    end
    n_cmp++;
    if (bus.overflow_out !== 1'b1 || enq_n !== 0) begin
      n_fail++; $display("FAIL overflow_sticky ovf=%b strobes=%0d want ovf=1 strobes=0",
                         bus.overflow_out, enq_n);
    end
    reset = 1;
    tick();
    reset = 0;
    n_cmp++;
    if (bus.overflow_out !== 1'b0) begin
      n_fail++; $display("FAIL overflow_cleared got=%b want=0", bus.overflow_out);
    end
    set_len(0);
    tick();
  endtask

  task automatic test_manual();
    int busy_n = 0, deq_n = 0;
    set_len(3);
    bus.auto_en_in = 0;
    bus.dequeue_req_in = 1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) bus.dequeue_req_in = 0;
      tick();
      n_cmp++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL manual_trace i=%0d got=%b want=%b", i, obs(), expv());
      end
      if (bus.busy_out) busy_n++;
      if (bus.dequeue_out) deq_n++;
    end
    n_cmp++;
    if (deq_n !== 1 || busy_n !== 1 + GAP) begin
      n_fail++; $display("FAIL manual_single deq=%0d busy=%0d want deq=1 busy=%0d",
                         deq_n, busy_n, 1 + GAP);
    end
  endtask

  task automatic test_auto_burst();
    int deq_at[$];
    int cnt_at[$];
    set_len(6);
    bus.auto_en_in = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL auto_trace i=%0d got=%b want=%b", i, obs(), expv());
      end
      if (bus.dequeue_out) begin
        deq_at.push_back(i);
        cnt_at.push_back(int'(bus.burst_cnt_out));
      end
    end
    bus.auto_en_in = 0;
    n_cmp++;
    if (deq_at.size() !== BURST) begin
      n_fail++; $display("FAIL auto_count got=%0d want=%0d", deq_at.size(), BURST);
    end else begin
      for (int k = 0; k < BURST; k++) begin
        n_cmp++;
        if (cnt_at[k] !== k + 1 || (k > 0 && deq_at[k] - deq_at[k-1] !== GAP + 1)) begin
          n_fail++; $display("FAIL auto_pulse k=%0d cnt=%0d spacing=%0d want cnt=%0d spacing=%0d",
                             k, cnt_at[k], (k > 0) ? deq_at[k] - deq_at[k-1] : 0, k + 1, GAP + 1);
        end
      end
    end
    n_cmp++;
    if (bus.busy_out !== 1'b0 || bus.burst_cnt_out !== 3'd0) begin
      n_fail++; $display("FAIL auto_idle busy=%b cnt=%0d want 0 0", bus.busy_out,
                         bus.burst_cnt_out);
    end
  endtask

  task automatic test_drain_early();
    int deq_n = 0, bad = 0;
    set_len(6);
    bus.auto_en_in = 1;
    tick();
    set_len(2);
    for (int i = 0; i < 15; i++) begin
      tick();
      n_cmp++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL drain_trace i=%0d got=%b want=%b", i, obs(), expv());
      end
      if (bus.dequeue_out) begin
        deq_n++;
        if (bus.len_in == 3'd0) bad++;
      end
    end
    bus.auto_en_in = 0;
    n_cmp++;
    if (deq_n !== 2 || bad !== 0 || bus.busy_out !== 1'b0) begin
      n_fail++; $display("FAIL drain_early deq=%0d on_empty=%0d busy=%b want 2 0 0",
                         deq_n, bad, bus.busy_out);
    end
    tick();
  endtask

  task automatic test_collision();
    set_len(3);
    bus.auto_en_in = 0;
    bus.dequeue_req_in = 1;
    tick();
    bus.data_ready_in = 1;
    tick();
    n_cmp++;
    if (bus.enqueue_out !== 1'b1 || bus.dequeue_out !== 1'b0 || obs() !== expv()) begin
      n_fail++; $display("FAIL collision_enq_first got=%b want=%b", obs(), expv());
    end
    tick();
    n_cmp++;
    if (bus.enqueue_out !== 1'b0 || bus.dequeue_out !== 1'b1 || obs() !== expv()) begin
      n_fail++; $display("FAIL collision_deq_slip got=%b want=%b", obs(), expv());
    end
    reset = 1;
    bus.data_ready_in = 0;
    bus.dequeue_req_in = 0;
    tick();
    reset = 0;
    n_cmp++;
    if (obs() !== 8'h00) begin
      n_fail++; $display("FAIL reset_mid_gap got=%b want=%b", obs(), 8'h00);
    end
    tick();
  endtask

  task automatic test_random();
    int both = 0;
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) bus.data_ready_in = ~bus.data_ready_in;
      if ($urandom_range(0, 4) == 0) bus.dequeue_req_in = ~bus.dequeue_req_in;
      if ($urandom_range(0, 29) == 0) bus.auto_en_in = ~bus.auto_en_in;
      if ($urandom_range(0, 19) == 0) set_len(int'($urandom_range(0, 7)));
      tick();
      n_cmp++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL random_trace i=%0d got=%b want=%b", i, obs(), expv());
      end
      if (bus.enqueue_out && bus.dequeue_out) both++;
    end
    reset = 0;
    n_cmp++;
    if (both !== 0) begin
      n_fail++; $display("FAIL random_exclusive overlaps=%0d want 0", both);
    end
  endtask

  initial begin
    reset = 1;
    bus.data_ready_in = 0;
    bus.dequeue_req_in = 0;
    bus.auto_en_in = 0;
    bus.len_in = 3'd0;
    @(negedge clk);
    test_reset();
    test_enqueue();
    test_overflow();
    test_manual();
    test_auto_burst();
    test_drain_early();
    test_collision();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
